kuuga_sc_nway_sim_top: RTL and testbench

- Self-contained simulation top for the n-way simple cache (sc_nway) study.
- A sequential instruction-fetch engine reads through an N-way set-associative, read-only instruction cache.
- Misses are filled over an AXI4-Lite read master from an internal AXI slave instance `axi_vip_0`. The benches load `axi_vip_0` by backdoor.
- A second AXI slave instance, `axi_vip_1`, is the data memory. Its master port is tied off.
- Every retired fetch is emitted as one trace record on `trace_data_o`.

---
 rtl/kuuga_sc_nway_sim_top.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_kuuga_sc_nway_sim_top.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/kuuga_sc_nway_sim_top.sv
// Simulation top for the n-way simple cache study: a sequential fetch engine behind a
// read-only set-associative I-cache, filled over AXI4-Lite from an internal slave model.
package kuuga_sc_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] instruction;
      logic        hit;
      logic [15:0] latency;
      logic        error;
   } trace_format;
endpackage

// One cache way: tag/valid/sticky-error/data arrays indexed by set, read combinationally.
module kuuga_sc_way #(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 3,
   parameter int WORD_W     = 2,
   parameter int TAG_W      = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] word,
   input  logic [TAG_W-1:0]  tag,
   input  logic              wr_en,
   input  logic              wr_last,
   input  logic [WORD_W-1:0] wr_word,
   input  logic [31:0]       wr_data,
   input  logic              wr_err,
   output logic              hit,
   output logic [31:0]       data,
   output logic              err
);
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS][LINE_WORDS];
   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  err_q;

   assign hit  = valid_q[idx] && (tag_q[idx] == tag);
   assign data = data_q[idx][word];
   assign err  = err_q[idx];

   // The error bit restarts with the first beat of a fill and accumulates over the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         err_q   <= '0;
      end else if (wr_en) begin
         err_q[idx] <= (wr_word == '0) ? wr_err : (err_q[idx] | wr_err);
         if (wr_last) valid_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) data_q[idx][wr_word] <= wr_data;
      if (wr_en && wr_last) tag_q[idx] <= tag;
   end
endmodule

// AXI4-Lite memory slave model with optional ARREADY delay and one SLVERR address.
module kuuga_axil_vip #(
   parameter int          MEM_WORDS = 1024,
   parameter int          AR_DELAY  = 0,
   parameter bit          ERR_EN    = 1'b0,
   parameter logic [31:0] ERR_ADDR  = 32'h0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready
);
   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0] mem [MEM_WORDS];
   logic [7:0]  dly;
   logic        wr_go;
   logic        unused_bits;

   assign wr_go   = awvalid && wvalid && !bvalid;
   assign awready = wr_go;
   assign wready  = wr_go;
   assign bresp   = 2'b00;
   assign arready = !rvalid && (dly == 8'(AR_DELAY));
   assign unused_bits = ^{awaddr[31:AW+2], awaddr[1:0], araddr[31:AW+2], araddr[1:0], arprot};

   always_ff @(posedge aclk) begin
      if (wr_go) mem[awaddr[AW+1:2]] <= wdata;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bvalid <= 1'b0;
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= 2'b00;
         dly    <= '0;
      end else begin
         if (wr_go)       bvalid <= 1'b1;
         else if (bready) bvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            dly    <= '0;
            if (ERR_EN && (araddr == ERR_ADDR)) begin
               rdata <= '0;
               rresp <= 2'b10;
            end else begin
               rdata <= mem[araddr[AW+1:2]];
               rresp <= 2'b00;
            end
         end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && !rvalid && (dly != 8'(AR_DELAY))) dly <= dly + 8'd1;
         end
      end
   end
endmodule

module kuuga_sc_nway_sim_top #(
   parameter int          WAYS          = 2,
   parameter int          SETS          = 8,
   parameter int          LINE_WORDS    = 4,
   parameter int          PROGRAM_WORDS = 200,
   parameter int          MEM_WORDS     = 1024,
   parameter int          AR_DELAY      = 0,
   parameter bit          ERR_EN        = 1'b0,
   parameter logic [31:0] ERR_ADDR      = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output kuuga_sc_pkg::trace_format trace_data_o
);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int OFF_W  = WORD_W + 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {LOOKUP = 2'd0, FILL_AR = 2'd1, FILL_R = 2'd2} state_t;

   state_t            state;
   logic [31:0]       pc;
   logic [31:0]       araddr;
   logic              arvalid, arready;
   logic              rvalid, rready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic [WORD_W-1:0] beat;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  rr [SETS];
   logic              hit_flag;
   logic [15:0]       lat, lat_next;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WORD_W-1:0] word;
   logic [31:0]       line_base;

   logic [WAYS-1:0]        way_hit, way_err;
   logic [WAYS-1:0][31:0]  way_data;
   logic                   hit_any, hit_err;
   logic [31:0]            hit_word;
   logic                   fill_we, fill_last;
   logic [31:0]            fill_data;

   assign idx       = pc[OFF_W +: IDX_W];
   assign tag       = pc[31 -: TAG_W];
   assign word      = pc[2 +: WORD_W];
   assign line_base = {pc[31:OFF_W], {OFF_W{1'b0}}};
   assign lat_next  = (lat == 16'hFFFF) ? lat : lat + 16'd1;

   assign fill_we   = (state == FILL_R) && rvalid && rready;
   assign fill_last = fill_we && (beat == WORD_W'(LINE_WORDS-1));
   assign fill_data = (rresp == 2'b00) ? rdata : 32'h0;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      kuuga_sc_way #(
         .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .WORD_W(WORD_W), .TAG_W(TAG_W)
      ) u_way (
         .clk     (clk),
         .rst_n   (rst_n),
         .idx     (idx),
         .word    (word),
         .tag     (tag),
         .wr_en   (fill_we && (victim == WAY_W'(w))),
         .wr_last (fill_last),
         .wr_word (beat),
         .wr_data (fill_data),
         .wr_err  (rresp != 2'b00),
         .hit     (way_hit[w]),
         .data    (way_data[w]),
         .err     (way_err[w])
      );
   end

   always_comb begin
      hit_any  = 1'b0;
      hit_word = '0;
      hit_err  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_hit[w]) begin
            hit_any  = 1'b1;
            hit_word = way_data[w];
            hit_err  = way_err[w];
         end
      end
   end

   // Latency counts every cycle spent on the current PC; it restarts at 1 after each emission.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOOKUP;
         pc           <= '0;
         araddr       <= '0;
         arvalid      <= 1'b0;
         rready       <= 1'b0;
         beat         <= '0;
         victim       <= '0;
         hit_flag     <= 1'b1;
         lat          <= 16'd1;
         trace_data_o <= '0;
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
      end else begin
         trace_data_o.valid <= 1'b0;
         case (state)
            LOOKUP: begin
               if (hit_any) begin
                  trace_data_o <= '{1'b1, pc, hit_word, hit_flag, lat, hit_err};
                  pc       <= (pc == 32'(4*(PROGRAM_WORDS-1))) ? 32'h0 : pc + 32'd4;
                  hit_flag <= 1'b1;
                  lat      <= 16'd1;
               end else begin
                  state   <= FILL_AR;
                  beat    <= '0;
                  victim  <= rr[idx];
                  araddr  <= line_base;
                  arvalid <= 1'b1;
                  lat     <= lat_next;
               end
            end
            FILL_AR: begin
               lat <= lat_next;
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= FILL_R;
               end
            end
            FILL_R: begin
               lat <= lat_next;
               if (rvalid) begin
                  rready <= 1'b0;
                  if (beat == WORD_W'(LINE_WORDS-1)) begin
                     rr[idx]  <= (rr[idx] == WAY_W'(WAYS-1)) ? '0 : rr[idx] + 1'b1;
                     hit_flag <= 1'b0;
                     state    <= LOOKUP;
                  end else begin
                     beat    <= beat + 1'b1;
                     araddr  <= line_base + (32'(beat) << 2) + 32'd4;
                     arvalid <= 1'b1;
                     state   <= FILL_AR;
                  end
               end
            end
            default: state <= LOOKUP;
         endcase
      end
   end

   // Instruction memory: read channel only, write side held idle.
   logic       i_awready, i_wready, i_bvalid;
   logic [1:0] i_bresp;

   kuuga_axil_vip #(
      .MEM_WORDS(MEM_WORDS), .AR_DELAY(AR_DELAY), .ERR_EN(ERR_EN), .ERR_ADDR(ERR_ADDR)
   ) axi_vip_0 (
      .aclk(clk), .aresetn(rst_n),
      .awaddr(32'h0), .awvalid(1'b0), .awready(i_awready),
      .wdata(32'h0), .wvalid(1'b0), .wready(i_wready),
      .bresp(i_bresp), .bvalid(i_bvalid), .bready(1'b0),
      .araddr(araddr), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // Data memory: present for the study, master side tied off.
   logic        d_awready, d_wready, d_bvalid, d_arready, d_rvalid;
   logic [1:0]  d_bresp, d_rresp;
   logic [31:0] d_rdata;
   logic        unused_axi;

   kuuga_axil_vip #(.MEM_WORDS(MEM_WORDS)) axi_vip_1 (
      .aclk(clk), .aresetn(rst_n),
      .awaddr(32'h0), .awvalid(1'b0), .awready(d_awready),
      .wdata(32'h0), .wvalid(1'b0), .wready(d_wready),
      .bresp(d_bresp), .bvalid(d_bvalid), .bready(1'b1),
      .araddr(32'h0), .arprot(3'b000), .arvalid(1'b0), .arready(d_arready),
      .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(1'b1)
   );

   assign unused_axi = ^{i_awready, i_wready, i_bresp, i_bvalid, d_awready, d_wready,
                         d_bresp, d_bvalid, d_arready, d_rdata, d_rresp, d_rvalid};
endmodule

// File: tb/tb_kuuga_sc_nway_sim_top.sv
// Directed bench: four instances (default, 16-word program, slow ARREADY, SLVERR on 0x8),
// each released from reset in turn and checked record by record.
module tb_kuuga_sc_nway_sim_top;
   import kuuga_sc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c, rst_d;
   trace_format tr_a, tr_b, tr_c, tr_d, tr_cur, rec;
   int sel = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit ok;
   int misses;

   kuuga_sc_nway_sim_top u_a (.clk(clk), .rst_n(rst_a), .trace_data_o(tr_a));
   kuuga_sc_nway_sim_top #(.PROGRAM_WORDS(16)) u_b (.clk(clk), .rst_n(rst_b), .trace_data_o(tr_b));
   kuuga_sc_nway_sim_top #(.AR_DELAY(5)) u_c (.clk(clk), .rst_n(rst_c), .trace_data_o(tr_c));
   kuuga_sc_nway_sim_top #(.ERR_EN(1'b1), .ERR_ADDR(32'h8)) u_d (.clk(clk), .rst_n(rst_d), .trace_data_o(tr_d));

   always_comb begin
      case (sel)
         1: tr_cur = tr_b;
         2: tr_cur = tr_c;
         3: tr_cur = tr_d;
         default: tr_cur = tr_a;
      endcase
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_rec(output trace_format r);
      bit got;
      got = 1'b0;
      r = '0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (tr_cur.valid === 1'b1) begin
            r = tr_cur;
            got = 1'b1;
         end
      end
      chk("record_timeout", {127'h0, got}, 128'h1);
   endtask

   // Compares {addr, instruction, hit, latency, error}.
   task automatic chk_rec(input string tag, input trace_format r, input logic [31:0] a,
                          input logic [31:0] ins, input logic h, input logic [15:0] l, input logic e);
      chk(tag, {r.addr, r.instruction, r.hit, r.latency, r.error}, {a, ins, h, l, e});
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         u_a.axi_vip_0.mem[i] = 32'(i);
         u_b.axi_vip_0.mem[i] = 32'(i);
         u_c.axi_vip_0.mem[i] = 32'(i);
         u_d.axi_vip_0.mem[i] = 32'(i);
      end
      repeat (3) @(negedge clk);
      chk("reset_trace_a", 128'(tr_a), 128'h0);
      chk("reset_trace_d", 128'(tr_d), 128'h0);
      chk("reset_ar", {126'h0, u_a.arvalid, u_a.rready}, 128'h0);

      // Cold start, default configuration
      sel = 0;
      rst_a = 1'b1;
      for (int k = 0; k < 200; k++) begin
         next_rec(rec);
         if (k == 0)      chk_rec("cold_first", rec, 32'h0, 32'h0, 1'b0, 16'd10, 1'b0);
         else if (k == 1) chk_rec("cold_second", rec, 32'h4, 32'h1, 1'b1, 16'd1, 1'b0);
         else if (k % 4 == 0) chk("line_start_hit", {rec.addr, rec.hit, rec.latency}, {32'(4*k), 1'b0, 16'd10});
         else if (k == 199) chk_rec("last_word", rec, 32'h31C, 32'd199, 1'b1, 16'd1, 1'b0);
         else chk("pass1_data", {rec.addr, rec.instruction, rec.hit}, {32'(4*k), 32'(k), 1'b1});
      end
      next_rec(rec);
      chk_rec("wrap_evicted", rec, 32'h0, 32'h0, 1'b0, 16'd10, 1'b0);
      next_rec(rec);
      chk_rec("wrap_next", rec, 32'h4, 32'h1, 1'b1, 16'd1, 1'b0);

      // Reset in the middle of the 0x10 refill
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (u_a.rready === 1'b1) ok = 1'b1;
      end
      chk("reach_fill_r", {127'h0, ok}, 128'h1);
      rst_a = 1'b0;
      #1;
      chk("midfill_reset_trace", 128'(tr_a), 128'h0);
      chk("midfill_reset_ar", {126'h0, u_a.arvalid, u_a.rready}, 128'h0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      next_rec(rec);
      chk_rec("restart_first", rec, 32'h0, 32'h0, 1'b0, 16'd10, 1'b0);

      // 16-word program: four cold misses, then an all-hit second pass
      sel = 1;
      rst_b = 1'b1;
      misses = 0;
      for (int k = 0; k < 16; k++) begin
         next_rec(rec);
         if (rec.hit === 1'b0) misses++;
      end
      chk("pw16_misses", 128'(misses), 128'd4);
      for (int k = 0; k < 16; k++) begin
         next_rec(rec);
         chk_rec("pw16_pass2", rec, 32'(4*k), 32'(k), 1'b1, 16'd1, 1'b0);
      end

      // ARREADY held off for 5 cycles: request must stay put
      sel = 2;
      rst_c = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("ar_hold", {u_c.arvalid, u_c.araddr, u_c.arready}, {1'b1, 32'h0, c == 5});
      end
      next_rec(rec);
      chk_rec("slow_first", rec, 32'h0, 32'h0, 1'b0, 16'd30, 1'b0);
      next_rec(rec);
      chk_rec("slow_second", rec, 32'h4, 32'h1, 1'b1, 16'd1, 1'b0);
      repeat (2) next_rec(rec);
      next_rec(rec);
      chk_rec("slow_line1", rec, 32'h10, 32'h4, 1'b0, 16'd30, 1'b0);

      // SLVERR on beat 2 of line 0
      sel = 3;
      rst_d = 1'b1;
      next_rec(rec);
      chk_rec("err_w0", rec, 32'h0, 32'h0, 1'b0, 16'd10, 1'b1);
      next_rec(rec);
      chk_rec("err_w1", rec, 32'h4, 32'h1, 1'b1, 16'd1, 1'b1);
      next_rec(rec);
      chk_rec("err_w2", rec, 32'h8, 32'h0, 1'b1, 16'd1, 1'b1);
      next_rec(rec);
      chk_rec("err_w3", rec, 32'hC, 32'h3, 1'b1, 16'd1, 1'b1);
      next_rec(rec);
      chk_rec("err_line1_clean", rec, 32'h10, 32'h4, 1'b0, 16'd10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
